// File: rtl/button_run_controller.sv
// Run/pause/clear sequencer for the lab counter, driven by one active-low push-button.
// Synchronize, debounce, classify short/long presses, then gate a periodic count strobe.
module button_run_controller #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 16,
  parameter int TICK_DIV          = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [1:0] state,
  output logic       short_press,
  output logic       long_press
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HCW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int TDW = $clog2(TICK_DIV);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCW-1:0] HC_LAST = HCW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HCW-1:0] HC_MAX  = HCW'(LONG_PRESS_CYCLES);
  localparam logic [TDW-1:0] TD_LAST = TDW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  logic           r_s1;
  logic           r_s2;
  logic           r_btnDb;
  logic [DBW-1:0] r_dbc;
  logic [HCW-1:0] r_hc;
  logic           r_longDone;
  logic           r_shortPress;
  logic           r_longPress;
  state_t         r_state;
  logic [TDW-1:0] r_td;
  logic           r_cntEn;
  logic           r_cntClr;

  logic w_dbMismatch;
  logic w_dbFlip;
  logic w_rise;
  logic w_holdHit;

  // w_rise fires on the very edge btn_db goes high, so a release beats a same-edge long threshold.
  always_comb begin
    w_dbMismatch = (r_s2 != r_btnDb);
    w_dbFlip     = w_dbMismatch && (r_dbc == DB_LAST);
    w_rise       = w_dbFlip && r_s2;
    w_holdHit    = !r_btnDb && (r_hc == HC_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_btnDb <= 1'b1;
      r_dbc   <= '0;
    end else begin
      r_s1 <= button;
      r_s2 <= r_s1;
      if (!w_dbMismatch) begin
        r_dbc <= '0;
      end else if (w_dbFlip) begin
        r_btnDb <= r_s2;
        r_dbc   <= '0;
      end else begin
        r_dbc <= r_dbc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hc         <= '0;
      r_longDone   <= 1'b0;
      r_shortPress <= 1'b0;
      r_longPress  <= 1'b0;
    end else begin
      r_shortPress <= w_rise && !r_longDone;
      r_longPress  <= w_holdHit && !r_longDone && !w_rise;
      if (r_btnDb) begin
        r_hc <= '0;
      end else if (r_hc != HC_MAX) begin
        r_hc <= r_hc + 1'b1;
      end
      if (w_rise) begin
        r_longDone <= 1'b0;
      end else if (w_holdHit) begin
        r_longDone <= 1'b1;
      end
    end
  end

  // The strobe is suppressed on the clear edge so the datapath never sees both at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_td     <= '0;
      r_cntEn  <= 1'b0;
      r_cntClr <= 1'b0;
    end else begin
      r_cntClr <= r_longPress;
      r_cntEn  <= (r_state == RUN) && (r_td == TD_LAST) && !r_longPress;
      case (r_state)
        RUN:     r_td <= (r_td == TD_LAST) ? '0 : r_td + 1'b1;
        PAUSE:   r_td <= r_td;
        default: r_td <= '0;
      endcase
      if (r_longPress) begin
        r_state <= IDLE;
      end else if (r_shortPress) begin
        case (r_state)
          IDLE:    r_state <= RUN;
          RUN:     r_state <= PAUSE;
          PAUSE:   r_state <= RUN;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign cnt_en      = r_cntEn;
  assign cnt_clr     = r_cntClr;
  assign state       = r_state;
  assign short_press = r_shortPress;
  assign long_press  = r_longPress;

endmodule

// File: tb/tb_button_run_controller.sv
// Scoreboard bench for button_run_controller: stimulus queues timed expected events,
// a negedge monitor pops and compares every event the DUT actually produces.
module tb_button_run_controller;

  localparam int EV_STATE = 0;
  localparam int EV_SHORT = 1;
  localparam int EV_LONG  = 2;
  localparam int EV_CLR   = 3;
  localparam int EV_EN    = 4;

  typedef struct {
    int kind;
    int at;
    int val;
  } evT;

  logic       clk = 1'b0;
  logic       reset;
  logic       button;
  logic       cnt_en;
  logic       cnt_clr;
  logic [1:0] state;
  logic       short_press;
  logic       long_press;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   monEn = 1'b0;
  logic [1:0] prevState = 2'b00;
  evT   expQ[$];

  button_run_controller #(
    .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(16),
    .TICK_DIV(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button(button),
    .cnt_en(cnt_en),
    .cnt_clr(cnt_clr),
    .state(state),
    .short_press(short_press),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kindName(input int kind);
    case (kind)
      EV_STATE: return "state";
      EV_SHORT: return "short_press";
      EV_LONG:  return "long_press";
      EV_CLR:   return "cnt_clr";
      default:  return "cnt_en";
    endcase
  endfunction

  task automatic pushExp(input int kind, input int at, input int val);
    evT ev;
    ev.kind = kind;
    ev.at   = at;
    ev.val  = val;
    expQ.push_back(ev);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic checkEvent(input int kind, input int val);
    evT ev;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected %s (val %0d) at cycle %0d, expected no event", kindName(kind), val, cyc);
    end else begin
      ev = expQ.pop_front();
      if (ev.kind != kind || ev.at != cyc || ev.val != val) begin
        errors++;
        $display("[TB] FAIL event: got %s val %0d at cycle %0d, expected %s val %0d at cycle %0d",
                 kindName(kind), val, cyc, kindName(ev.kind), ev.val, ev.at);
      end
    end
  endtask

  // Outputs change only on posedge, so the negedge view is stable.
  always @(negedge clk) begin
    if (monEn) begin
      while (expQ.size() > 0 && expQ[0].at < cyc) begin
        evT ev;
        ev = expQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missed %s val %0d due at cycle %0d, now cycle %0d", kindName(ev.kind), ev.val, ev.at, cyc);
      end
      if (state != prevState) checkEvent(EV_STATE, int'(state));
      if (short_press) checkEvent(EV_SHORT, 0);
      if (long_press)  checkEvent(EV_LONG, 0);
      if (cnt_clr)     checkEvent(EV_CLR, 0);
      if (cnt_en)      checkEvent(EV_EN, 0);
      prevState = state;
    end
  end

  task automatic waitUntil(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int lowCycles);
    button = 1'b0;
    repeat (lowCycles) @(negedge clk);
    button = 1'b1;
  endtask

  initial begin
    int c0, c2, c3, c4, c5, c6;
    reset  = 1'b1;
    button = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset state", int'(state), 0);
    checkOutput("reset cnt_en", int'(cnt_en), 0);
    checkOutput("reset cnt_clr", int'(cnt_clr), 0);
    checkOutput("reset short_press", int'(short_press), 0);
    checkOutput("reset long_press", int'(long_press), 0);
    reset = 1'b0;
    monEn = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("idle state", int'(state), 0);

    // One-cycle glitches never survive the debouncer.
    repeat (5) begin
      button = 1'b0;
      @(negedge clk);
      button = 1'b1;
      repeat (49) @(negedge clk);
    end
    checkOutput("glitch state", int'(state), 0);

    // Short press to RUN, then a pause press that lands with td held at 3.
    c0 = cyc;
    pushExp(EV_SHORT, c0 + 14, 0);
    pushExp(EV_STATE, c0 + 15, 1);
    pushExp(EV_EN,    c0 + 25, 0);
    pushExp(EV_EN,    c0 + 35, 0);
    pushExp(EV_EN,    c0 + 45, 0);
    pushExp(EV_SHORT, c0 + 47, 0);
    pushExp(EV_STATE, c0 + 48, 2);
    applyStimulus(8);
    waitUntil(c0 + 33);
    applyStimulus(8);
    waitUntil(c0 + 90);
    checkOutput("pause state", int'(state), 2);
    waitUntil(c0 + 93);

    // Resume: first strobe 10-3 cycles after RUN.
    c2 = cyc;
    pushExp(EV_SHORT, c2 + 14, 0);
    pushExp(EV_STATE, c2 + 15, 1);
    pushExp(EV_EN,    c2 + 22, 0);
    pushExp(EV_EN,    c2 + 32, 0);
    pushExp(EV_EN,    c2 + 42, 0);
    applyStimulus(8);
    waitUntil(c2 + 29);

    // Long press whose clear edge coincides with a divider wrap.
    c3 = cyc;
    pushExp(EV_LONG,  c3 + 22, 0);
    pushExp(EV_STATE, c3 + 23, 0);
    pushExp(EV_CLR,   c3 + 23, 0);
    applyStimulus(30);
    waitUntil(c3 + 50);
    checkOutput("after long state", int'(state), 0);

    c4 = cyc;
    pushExp(EV_LONG, c4 + 22, 0);
    pushExp(EV_CLR,  c4 + 23, 0);
    applyStimulus(20);
    waitUntil(c4 + 45);

    // Fifteen debounced-low cycles stays a short press.
    c5 = cyc;
    pushExp(EV_SHORT, c5 + 21, 0);
    pushExp(EV_STATE, c5 + 22, 1);
    pushExp(EV_EN,    c5 + 32, 0);
    pushExp(EV_EN,    c5 + 42, 0);
    pushExp(EV_EN,    c5 + 52, 0);
    applyStimulus(15);
    waitUntil(c5 + 45);

    // Reset in the middle of a held press; the press is re-detected from scratch.
    c6 = cyc;
    button = 1'b0;
    pushExp(EV_STATE, c6 + 11, 0);
    waitUntil(c6 + 10);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pushExp(EV_SHORT, c6 + 26, 0);
    pushExp(EV_STATE, c6 + 27, 1);
    pushExp(EV_EN,    c6 + 37, 0);
    waitUntil(c6 + 20);
    button = 1'b1;
    waitUntil(c6 + 45);
    checkOutput("final state", int'(state), 1);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending events: got %0d left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_run_controller.md
# button_run_controller

Sequencer that turns the board's raw active-low push-button into run/pause/clear control for the lab counter datapath. It synchronizes and debounces the button, classifies each press as short or long, and runs a three-state FSM that gates a periodic count-enable strobe and issues counter clears. It sits between the top-level `button` pin and the counter/display datapath, and replaces ad-hoc button handling in the top level.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the debounced level changes; minimum 1.
- `LONG_PRESS_CYCLES`, default 16: debounced-low cycles that make a press "long"; must be greater than 1.
- `TICK_DIV`, default 10: period in clocks of `cnt_en` while running; minimum 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `button`  in  1  raw asynchronous push-button; active-low, where 0 means pressed.
- `cnt_en`  out  1  one-cycle count strobe to the datapath.
- `cnt_clr`  out  1  one-cycle clear pulse to the datapath.
- `state`  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE; 11 is never driven.
- `short_press`  out  1  one-cycle pulse per short press.
- `long_press`  out  1  one-cycle pulse per long press.

## Operation
- Reset dominates every other event. While `reset` = 1, at each edge:
  - the synchronizer flops, debounced level `btn_db` and press-active flag load 1, 1 and 0;
  - all counters load 0;
  - `state` loads IDLE;
  - `cnt_en`, `cnt_clr`, `short_press` and `long_press` load 0.
- Synchronizer: two flops (`s1`, `s2`) on `button`; no logic between them.
- Debounce:
  - counter `dbc` increments while `s2` != `btn_db`; it resets to 0 when they match.
  - When `dbc` = `DEBOUNCE_CYCLES`-1 and a mismatch is still present, `btn_db` takes `s2` and `dbc` clears.
  - A low excursion shorter than `DEBOUNCE_CYCLES` cycles at `s2` produces no `btn_db` change.
- Press classifier:
  - Hold counter `hc` counts cycles with `btn_db` = 0 and saturates at `LONG_PRESS_CYCLES`. It clears when `btn_db` = 1.
  - `long_press` = 1 for exactly one cycle, registered, on the edge where `hc` reaches `LONG_PRESS_CYCLES`. A flag `long_done` blocks any repeat within the same press.
  - On the `btn_db` 0->1 edge: if `long_done` = 0, `short_press` = 1 for one cycle, registered. Then `long_done` clears.
  - A release and the long threshold arriving in the same cycle count as a release: the press is short, and no `long_press` is issued.
- FSM (next state evaluated from the registered pulses, so a transition lands one edge after its pulse):
  - IDLE --short--> RUN
  - RUN --short--> PAUSE
  - PAUSE --short--> RUN
  - any --long--> IDLE; `cnt_clr` = 1 on that same transition edge, for one cycle. This includes a long press while already in IDLE.
- Tick divider `td` (range 0..`TICK_DIV`-1):
  - RUN: increments, wrapping to 0 after `TICK_DIV`-1. `cnt_en` = 1, registered, on the edge where `td` wraps.
  - PAUSE: `td` holds its value (phase is preserved) and `cnt_en` = 0.
  - IDLE: `td` = 0 and `cnt_en` = 0.
  - `cnt_en` and `cnt_clr` are never 1 in the same cycle.

## Timing
- Let the raw press first be sampled low at edge k and stay stable. Then:
  - `s2` is low after edge k+1;
  - `btn_db` falls at edge k+1+`DEBOUNCE_CYCLES`.
- Release follows the same path: `btn_db` rises `DEBOUNCE_CYCLES`+1 edges after the first high sample.
- `short_press` is high for the cycle after the `btn_db` rising edge. `state` changes on the next edge.
- `long_press` is high for the cycle after `btn_db` has been low for `LONG_PRESS_CYCLES` cycles. `state` = IDLE and `cnt_clr` = 1 follow one edge later.
- IDLE->RUN: the first `cnt_en` occurs `TICK_DIV` cycles after `state` becomes 01. After that, `cnt_en` repeats every `TICK_DIV` cycles.
- PAUSE->RUN with held phase p: the next `cnt_en` occurs `TICK_DIV`-p cycles after `state` becomes 01.
- Reset mid-press with `button` still low: after reset releases, the press is re-detected as a new press with full debounce latency. No pulse from the interrupted press is emitted.

## Test plan
- Reset: hold `reset` = 1 for 2 cycles with `button` = 1 -> `state` = 00 and all pulse outputs 0. Then run 50 idle cycles -> outputs remain 0.
- Glitch: in IDLE, drive `button` = 0 for 1 cycle every 50 cycles, 5 times -> no `short_press`, no `long_press`, `state` stays 00.
- Short press: `button` = 0 for 8 cycles (`DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=16, `TICK_DIV`=10) -> exactly one `short_press`, `state` = 01. Then `cnt_en` pulses every 10 cycles, the first 10 cycles after entering RUN.
- Pause/resume: in RUN, issue a short press when `td` = 3 -> `state` = 10 and `cnt_en` stays 0 for 40 cycles. Issue another short press -> `state` = 01, and the first `cnt_en` comes 7 cycles later.
- Long press: in RUN, `button` = 0 for 30 cycles -> one `long_press` 16 cycles after `btn_db` falls, then `state` = 00 with one `cnt_clr` cycle. On release there is no `short_press` and no further `cnt_en`.
- Boundary and reset: a press with exactly 15 debounced-low cycles -> `short_press` only. `reset` asserted during a held press, then released with `button` still low -> no pulse until a fresh debounce completes, then normal classification.
